result_display: RTL and testbench
=================================

# result_display

Output stage downstream of the GCD `Processor`. On each rising edge of `Halt` it captures the 8-bit result on `Moutput` and converts it to BCD with a sequential double-dabble. It then drives a 4-digit multiplexed active-low seven-segment display: three decimal result digits plus one hex digit showing `DisplayState`. It gives the board a human-readable result and FSM state without any change to the processor.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit stays selected; must be ≥2.
- `LEAD_BLANK`, default 1: 1 blanks leading zeros of the result; 0 shows all three digits.

Ports:
- `clock`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `Halt`  in  1  processor done flag; a rising edge triggers capture.
- `Moutput`  in  8  processor result, unsigned.
- `DisplayState`  in  4  processor FSM state, shown as a hex digit.
- `an`  out  4  digit anodes, active-low, exactly one low at a time.
- `seg`  out  7  segments, active-low, `{g,f,e,d,c,b,a}`.
- `busy`  out  1  conversion in progress.
- `valid`  out  1  a converted result is held.

## Operation
- Edge detect: `halt_q` register, reset value 0. Capture when `Halt && !halt_q`, so `Halt` high straight out of reset captures on the first cycle.
- FSM states:
  - IDLE → CONV on capture: load `Moutput` into the shift register, clear the scratch BCD, set bit counter to 0.
  - CONV: 8 shift/add-3 iterations (add 3 to any BCD nibble ≥5, then shift left 1).
  - After the 8th iteration: copy scratch BCD into the display BCD registers (hundreds, tens, ones), set `valid`=1, return to IDLE.
- Capture while in CONV restarts conversion with the new `Moutput`; the latest value wins and no partial result is ever displayed.
- Display BCD registers change only at conversion completion. They hold the last value while `Halt` falls and during a reconversion.
- `valid` clears only on reset.
- Digit mapping:
  - digit 3 = hex of `DisplayState`.
  - digits 2/1/0 = hundreds/tens/ones.
- Digits 2..0 while `valid`=0: dash (`seg`=7'b0111111).
- With `LEAD_BLANK`=1:
  - hundreds blank if 0.
  - tens blank if hundreds and tens are both 0.
  - ones always shown.
  - Blank = 7'b1111111.
- Scan: prescaler counts 0..`SCAN_DIV`-1. On wrap the digit index increments 0→1→2→3→0. `an` = ~(1<<index).

## Timing
- Reset values: `an`=4'b1110, `seg`=7'b0111111, `busy`=0, `valid`=0, digit index 0, prescaler 0, BCD 0, FSM IDLE.
- Capture at edge N: `busy`=1 after edge N.
- Iterations run at edges N+1..N+8. After edge N+8: BCD updated, `valid`=1, `busy`=0.
- Latency is 8 cycles from capture to `valid`.
- `an` and `seg` are registered, so they reflect index/BCD one cycle later. A new result appears on `seg` one cycle after `valid` rises, on whichever digit is selected.
- Digit change: `an` changes the cycle after prescaler wrap. No cycle may have two anodes low; a cycle with all anodes high is not permitted either.
- Reset mid-conversion: the conversion aborts and all reset values apply after that edge.
- Capture and completion on the same edge: the completing value is discarded and the new conversion starts.

## Structure
- Shared package `display_pkg`:
  - SEG_DASH and SEG_BLANK constants.
  - hex-to-seg function for 0–F, active-low `{g..a}`.
  - NUM_DIGITS=4.
  - FSM state typedef (IDLE, CONV).
- One sub-module: `bin2bcd_seq`. It holds the 8-bit → 3-nibble sequential double-dabble with start/busy/done. The top holds edge detect, result registers and scan/mux.

## Test plan
All scenarios use `SCAN_DIV`=4.
- Reset held low 2 cycles, then released → `an`=1110, `seg`=0111111, `busy`=0, `valid`=0; `an` steps 1110→1101→1011→0111 every 4 cycles.
- `Moutput`=91, `Halt` rising → `busy` for 8 cycles, then `valid`=1. Digits show hundreds blank, tens 0010000 (9), ones 1111001 (1).
- `Moutput`=255 → digits 0100100 (2), 0010010 (5), 0010010 (5). With `LEAD_BLANK`=0 and `Moutput`=7 → 1000000, 1000000, 1111000.
- `Moutput`=0 → hundreds and tens blank, ones 1000000. With `DisplayState`=4'hA, digit 3 shows 0001000.
- Capture 91, then a second `Halt` rising edge with `Moutput`=7 at cycle 4 of conversion → BCD never shows 91. Final digits are blank, blank, 1111000, and `valid` rises 8 cycles after the second capture.
- `reset` low during CONV → after that edge `valid`=0, `busy`=0, digits 2..0 show dash.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, segment encoder and conversion FSM type for the result display.
package display_pkg;

   localparam int NUM_DIGITS = 4;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_t;

   // Hex digit 0..F to active-low seven-segment pattern
   function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
      logic [6:0] s;
      case (val)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/result_display_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD nibbles, one iteration per clock.
// start_i always (re)loads, even mid-conversion; done_o is suppressed when a restart
// coincides with the final iteration so a superseded result is never reported.
module bin2bcd_seq
   import display_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start_i,
   input  logic [7:0]  bin_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [11:0] bcd_o
);

   conv_state_t state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [11:0] bcd_adj;
   logic [19:0] shifted;
   logic        last_iter;

   // Add-3 correction on every nibble that is 5 or more before the shift
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                     (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
      end
   endgenerate

   assign shifted   = {bcd_adj, bin_q} << 1;
   assign last_iter = (state_q == CONV) && (cnt_q == 3'd7);

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: start wins over everything, otherwise iterate while converting
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      if (start_i) begin
         state_d = CONV;
         bin_d   = bin_i;
         bcd_d   = '0;
         cnt_d   = '0;
      end else if (state_q == CONV) begin
         bin_d = shifted[7:0];
         bcd_d = shifted[19:8];
         cnt_d = cnt_q + 3'd1;
         if (last_iter) begin
            state_d = IDLE;
         end
      end
   end

   // Outputs: result is the combinational value of the final iteration
   always_comb begin
      busy_o = (state_q == CONV);
      done_o = last_iter && !start_i;
      bcd_o  = shifted[19:8];
   end

endmodule

// File: rtl/result_display.sv
// Captures the processor result on a rising Halt, converts it to BCD and drives a
// 4-digit multiplexed active-low display: state hex digit plus three result digits.
module result_display
   import display_pkg::*;
#(
   parameter int SCAN_DIV   = 1024,
   parameter bit LEAD_BLANK = 1'b1
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       Halt,
   input  logic [7:0] Moutput,
   input  logic [3:0] DisplayState,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       busy,
   output logic       valid
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

   logic          halt_q, halt_d;
   logic [11:0]   bcd_q, bcd_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic          capture;
   logic          conv_busy;
   logic          conv_done;
   logic [11:0]   conv_bcd;
   logic [6:0]    digit_seg [NUM_DIGITS];
   logic [3:0]    hund, tens, ones;

   assign capture = Halt && !halt_q;

   bin2bcd_seq u_conv (
      .clock   (clock),
      .reset   (reset),
      .start_i (capture),
      .bin_i   (Moutput),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd)
   );

   assign hund = bcd_q[11:8];
   assign tens = bcd_q[7:4];
   assign ones = bcd_q[3:0];

   // Per-digit segment pattern: dashes until a result exists, optional leading-zero blanking
   always_comb begin
      digit_seg[3] = hex_to_seg(DisplayState);
      digit_seg[2] = SEG_DASH;
      digit_seg[1] = SEG_DASH;
      digit_seg[0] = SEG_DASH;
      if (valid_q) begin
         digit_seg[2] = (LEAD_BLANK && (hund == 4'd0)) ? SEG_BLANK : hex_to_seg(hund);
         digit_seg[1] = (LEAD_BLANK && (hund == 4'd0) && (tens == 4'd0)) ?
                        SEG_BLANK : hex_to_seg(tens);
         digit_seg[0] = hex_to_seg(ones);
      end
   end

   // Next state: edge detect, result hold, scan prescaler and registered display drive
   always_comb begin
      halt_d     = Halt;
      bcd_d      = conv_done ? conv_bcd : bcd_q;
      valid_d    = valid_q | conv_done;
      prescale_d = (prescale_q == PS_LAST) ? '0 : (prescale_q + PW'(1));
      idx_d      = (prescale_q == PS_LAST) ? (idx_q + 2'd1) : idx_q;
      an_d       = ~(4'b0001 << idx_q);
      seg_d      = digit_seg[idx_q];
   end

   // Registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         halt_q     <= 1'b0;
         bcd_q      <= '0;
         valid_q    <= 1'b0;
         prescale_q <= '0;
         idx_q      <= '0;
         an_q       <= 4'b1110;
         seg_q      <= SEG_DASH;
      end else begin
         halt_q     <= halt_d;
         bcd_q      <= bcd_d;
         valid_q    <= valid_d;
         prescale_q <= prescale_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign busy  = conv_busy;
   assign valid = valid_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized scoreboard bench for result_display; two instances (leading-zero
// blanking on and off) share all stimulus.
module tb_result_display;

   localparam int SD = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       Halt;
   logic [7:0] Moutput;
   logic [3:0] DisplayState;
   logic [3:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       busy_a, busy_b, valid_a, valid_b;

   typedef struct {
      int v;
      int cap;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         since_rst = 0;
   bit         rst_seen = 1'b0;
   logic [3:0] ds_edge = 4'h0;
   int         shown = -1;
   bit         busy_prev = 1'b0;
   logic [6:0] seg_tab [16];

   result_display #(.SCAN_DIV(SD), .LEAD_BLANK(1'b1)) dut (
      .clock(clock), .reset(reset), .Halt(Halt), .Moutput(Moutput),
      .DisplayState(DisplayState), .an(an_a), .seg(seg_a), .busy(busy_a), .valid(valid_a)
   );

   result_display #(.SCAN_DIV(SD), .LEAD_BLANK(1'b0)) dut_nb (
      .clock(clock), .reset(reset), .Halt(Halt), .Moutput(Moutput),
      .DisplayState(DisplayState), .an(an_b), .seg(seg_b), .busy(busy_b), .valid(valid_b)
   );

   always #5 clock = ~clock;

   // Edge bookkeeping: cycle count, reset seen, cycles since reset, state digit at the edge
   always @(posedge clock) begin
      cyc       <= cyc + 1;
      rst_seen  <= !reset;
      since_rst <= (!reset) ? 0 : since_rst + 1;
      ds_edge   <= DisplayState;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference digit: decimal split of the held value, dash before any result
   function automatic logic [6:0] model_seg(input int v, input int idx, input logic [3:0] ds,
                                            input bit lb);
      int h, t, o;
      if (idx == 3) return seg_tab[ds];
      if (v < 0) return 7'b0111111;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (idx == 2) return (lb && h == 0) ? 7'b1111111 : seg_tab[h];
      if (idx == 1) return (lb && h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
      return seg_tab[o];
   endfunction

   // Monitor: checks scan, segments and flags every cycle; pops the scoreboard on completion
   always @(negedge clock) begin
      int         idx;
      bit         fall;
      logic [3:0] exp_an;
      exp_t       e;
      if (cyc > 0) begin
         if (rst_seen) begin
            check("rst_an", an_a, 4'b1110);
            check("rst_an_nb", an_b, 4'b1110);
            check("rst_seg", seg_a, 7'b0111111);
            check("rst_seg_nb", seg_b, 7'b0111111);
            check("rst_busy", busy_a, 1'b0);
            check("rst_valid", valid_a, 1'b0);
            check("rst_valid_nb", valid_b, 1'b0);
            shown = -1;
         end else begin
            idx    = (since_rst == 0) ? 0 : ((since_rst - 1) / SD) % 4;
            exp_an = ~(4'b0001 << idx);
            check("an", an_a, exp_an);
            check("an_nb", an_b, exp_an);
            check("seg", seg_a, model_seg(shown, idx, ds_edge, 1'b1));
            check("seg_nb", seg_b, model_seg(shown, idx, ds_edge, 1'b0));
            check("busy_nb", busy_b, busy_a);
            fall = busy_prev && !busy_a;
            check("valid", valid_a, (shown >= 0) || fall);
            check("valid_nb", valid_b, (shown >= 0) || fall);
            if (fall) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done: got completion want none (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("latency", cyc - e.cap, 8);
                  shown = e.v;
                  $display("done value=%0d latency=%0d cycle=%0d", e.v, cyc - e.cap, cyc);
               end
            end
         end
         busy_prev = busy_a;
      end
   end

   // Pulse Halt for one edge; capture happens on the next clock edge
   task automatic drive_capture(input logic [7:0] v, input bit push);
      Moutput = v;
      Halt    = 1'b1;
      if (push) exp_q.push_back('{v: int'(v), cap: cyc + 1});
      @(posedge clock); #1;
      Halt    = 1'b0;
      Moutput = 8'($urandom);
   endtask

   task automatic run_one(input logic [7:0] v, input logic [3:0] ds);
      DisplayState = ds;
      drive_capture(v, 1'b1);
      repeat (26) @(posedge clock);
      #1;
   endtask

   initial begin
      int off;
      logic [7:0] v, v2;
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      reset        = 1'b0;
      Halt         = 1'b0;
      Moutput      = 8'd0;
      DisplayState = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (20) @(posedge clock);
      #1;

      run_one(8'd91, 4'h1);
      run_one(8'd255, 4'h2);
      run_one(8'd7, 4'h5);
      run_one(8'd0, 4'hA);

      // Restart at cycle 4 of conversion: 91 must never reach the display
      DisplayState = 4'h3;
      drive_capture(8'd91, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      drive_capture(8'd7, 1'b1);
      repeat (30) @(posedge clock);
      #1;

      // Halt already high when reset releases captures on the first edge
      reset   = 1'b0;
      Halt    = 1'b1;
      Moutput = 8'd123;
      @(posedge clock); #1;
      reset = 1'b1;
      exp_q.push_back('{v: 123, cap: cyc + 1});
      @(posedge clock); #1;
      Halt = 1'b0;
      repeat (28) @(posedge clock);
      #1;

      // Reset in the middle of a conversion aborts it
      drive_capture(8'd200, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (20) @(posedge clock);
      #1;

      // Random captures, some restarted mid-conversion or on the completion edge
      for (int i = 0; i < 30; i++) begin
         v = 8'($urandom_range(0, 255));
         DisplayState = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            off = $urandom_range(2, 8);
            v2  = 8'($urandom_range(0, 255));
            drive_capture(v, 1'b0);
            repeat (off - 1) @(posedge clock);
            #1;
            drive_capture(v2, 1'b1);
         end else begin
            drive_capture(v, 1'b1);
         end
         repeat ($urandom_range(9, 26)) @(posedge clock);
         #1;
      end

      repeat (10) @(posedge clock);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
